alu_wb_queue: RTL and testbench
===============================

Name: alu_wb_queue

Overview:
- Per-functional-unit writeback queue that sits directly upstream of the register-file write arbiter.
- One instance each for simd0..3 and simf0..3; it buffers completed ALU results (destination, wavefront, exec mask, data).
- Presents the head entry as queue_entry_valid and pops it when the arbiter returns queue_entry_serviced.
- Decouples ALU completion timing from arbiter grant latency and from LSU/SALU write priority.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DATA_WIDTH, 2048, write data width (64 lanes x 32 bits).
- ADDR_WIDTH, 10, destination register address width (VGPR/SGPR).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- enq_valid  input  1  ALU offers a result this cycle
- enq_ready  output  1  queue can accept; registered, equals not-full
- enq_dest_addr  input  ADDR_WIDTH  destination register address
- enq_wfid  input  6  wavefront id
- enq_is_vgpr  input  1  1 = VGPR write, 0 = SGPR write
- enq_exec_mask  input  64  lane write enables
- enq_data  input  DATA_WIDTH  result data
- flush  input  1  discard all entries (wavefront halt / pipeline flush)
- queue_entry_valid  output  1  head entry present, to arbiter
- queue_entry_serviced  input  1  arbiter grant; pops head
- head_dest_addr  output  ADDR_WIDTH  head entry field
- head_wfid  output  6  head entry field
- head_is_vgpr  output  1  head entry field
- head_exec_mask  output  64  head entry field
- head_data  output  DATA_WIDTH  head entry field
- occupancy  output  log2(DEPTH)+1  current entry count
- err_sticky  output  1  overflow/underflow seen since reset

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0; queue_entry_valid=0; enq_ready=1; occupancy=0; err_sticky=0.
  - head_* fields are don't-care and are driven from storage at the read pointer.
  - Storage is not reset.
- Enqueue: enq_valid and enq_ready at a rising edge writes the entry at wr_ptr and increments wr_ptr modulo DEPTH.
- Dequeue: queue_entry_serviced and queue_entry_valid at a rising edge increments rd_ptr modulo DEPTH.
- Latency:
  - An entry enqueued into an empty queue raises queue_entry_valid the next cycle. There is no same-cycle bypass.
  - After a pop, the next entry is visible on head_* the following cycle.
- queue_entry_valid = (count != 0), driven from registers only. There is no combinational path from enq_* or serviced to valid.
- enq_ready = (count != DEPTH), registered. There is no combinational path from serviced to enq_ready, so enqueue is refused when full even if a pop occurs in the same cycle.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointer wrap: pointers carry log2(DEPTH) bits and wrap naturally. count is a separate register of width log2(DEPTH)+1.
- Error cases (each sets err_sticky, which clears only on reset):
  - enq_valid with enq_ready=0 (overflow attempt): entry is dropped, state is unchanged.
  - serviced with valid=0 (underflow): ignored, state is unchanged.
- Flush:
  - Synchronous; count and pointers go to 0 at the next edge.
  - Flush has priority over a same-cycle enqueue (entry dropped, no error) and over a same-cycle serviced (pop is a no-op).
  - enq_ready reads 1 on the cycle after flush.
- occupancy = count.

Optional Feature:
- Macro: ALU_WB_QUEUE_STALL_STATS_EN.
- Enabled:
  - Adds output stall_cycles[15:0]: a saturating counter incremented each cycle with queue_entry_valid=1 and queue_entry_serviced=0.
  - Adds output full_cycles[15:0]: a saturating counter incremented each cycle with count==DEPTH.
  - Both saturate at 16'hFFFF, are cleared by reset, and are not cleared by flush.
- Disabled: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/definitions include:
  - WFID_WIDTH=6, EXEC_MASK_WIDTH=64, default VGPR data width 2048, register address width 10.
  - Packed writeback-entry layout with field offsets, also used by the arbiter's consumer mux.
- One natural sub-module, wbq_storage: DEPTH x entry-width register array with synchronous write port and asynchronous read at rd_ptr.
- Pointer, count, error and stats logic stay in alu_wb_queue.

Test Plan:
- Reset then enqueue addr=10'h012, wfid=5, mask=all-ones -> valid=1 the next cycle, head_dest_addr=10'h012, occupancy=1; serviced -> valid=0 the cycle after.
- Enqueue 4 entries with serviced held low (DEPTH=4) -> enq_ready=0 after the 4th edge; 5th enq_valid -> dropped, err_sticky=1; pop order is addr 1,2,3,4.
- Count=2; enqueue and serviced in the same cycle -> occupancy stays 2; head advances to entry 2; new entry appears last.
- Fill to full, then enqueue+serviced in the same cycle -> enqueue refused, occupancy=3, err_sticky=1.
- Count=3, flush with enq_valid and serviced high -> occupancy=0, valid=0 next cycle, err_sticky unchanged; rst pulsed low mid-stream -> outputs take reset values immediately without waiting for clk.
- With ALU_WB_QUEUE_STALL_STATS_EN: one entry, serviced withheld 7 cycles -> stall_cycles=7; hold full 70000 cycles -> full_cycles=16'hFFFF.

Source files
------------

// File: rtl/alu_wb_queue_pkg.sv
// alu_wb_queue_pkg
// Shared definitions for the ALU writeback queue and its consumers.
// Writeback entry layout, LSB to MSB: data, exec_mask, is_vgpr, wfid, dest_addr.
// The offset helpers below give field positions for any data width.
// The register-file write arbiter's consumer mux uses the same helpers.
package alu_wb_queue_pkg;

    localparam int WFID_WIDTH      = 6;
    localparam int EXEC_MASK_WIDTH = 64;
    localparam int DEF_DATA_WIDTH  = 2048;
    localparam int DEF_ADDR_WIDTH  = 10;

    // Entry at the default widths; member order matches the offset helpers.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  dest_addr;
        logic [WFID_WIDTH-1:0]      wfid;
        logic                       is_vgpr;
        logic [EXEC_MASK_WIDTH-1:0] exec_mask;
        logic [DEF_DATA_WIDTH-1:0]  data;
    } wb_entry_t;

    function automatic int entry_mask_lsb(input int dw);
        return dw;
    endfunction

    function automatic int entry_vgpr_bit(input int dw);
        return dw + EXEC_MASK_WIDTH;
    endfunction

    function automatic int entry_wfid_lsb(input int dw);
        return dw + EXEC_MASK_WIDTH + 1;
    endfunction

    function automatic int entry_addr_lsb(input int dw);
        return dw + EXEC_MASK_WIDTH + 1 + WFID_WIDTH;
    endfunction

    function automatic int entry_width(input int aw, input int dw);
        return entry_addr_lsb(dw) + aw;
    endfunction

endpackage

// File: rtl/alu_wb_queue_if.sv
// alu_wb_queue_if
// Bundles the ALU enqueue side, the arbiter dequeue side, and the queue status.
// Modport master: the ALU/arbiter side. Modport slave: the queue itself.
// With ALU_WB_QUEUE_STALL_STATS_EN defined, the interface also carries
// stall_cycles and full_cycles.
interface alu_wb_queue_if
    import alu_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       enq_valid;
    logic                       enq_ready;
    logic [ADDR_WIDTH-1:0]      enq_dest_addr;
    logic [WFID_WIDTH-1:0]      enq_wfid;
    logic                       enq_is_vgpr;
    logic [EXEC_MASK_WIDTH-1:0] enq_exec_mask;
    logic [DATA_WIDTH-1:0]      enq_data;
    logic                       flush;
    logic                       queue_entry_valid;
    logic                       queue_entry_serviced;
    logic [ADDR_WIDTH-1:0]      head_dest_addr;
    logic [WFID_WIDTH-1:0]      head_wfid;
    logic                       head_is_vgpr;
    logic [EXEC_MASK_WIDTH-1:0] head_exec_mask;
    logic [DATA_WIDTH-1:0]      head_data;
    logic [CNT_W-1:0]           occupancy;
    logic                       err_sticky;
`ifdef ALU_WB_QUEUE_STALL_STATS_EN
    logic [15:0]                stall_cycles;
    logic [15:0]                full_cycles;
`endif

    modport master (
        output enq_valid, enq_dest_addr, enq_wfid, enq_is_vgpr, enq_exec_mask,
               enq_data, flush, queue_entry_serviced,
        input  enq_ready, queue_entry_valid, head_dest_addr, head_wfid,
               head_is_vgpr, head_exec_mask, head_data, occupancy,
`ifdef ALU_WB_QUEUE_STALL_STATS_EN
               stall_cycles, full_cycles,
`endif
               err_sticky
    );

    modport slave (
        input  enq_valid, enq_dest_addr, enq_wfid, enq_is_vgpr, enq_exec_mask,
               enq_data, flush, queue_entry_serviced,
        output enq_ready, queue_entry_valid, head_dest_addr, head_wfid,
               head_is_vgpr, head_exec_mask, head_data, occupancy,
`ifdef ALU_WB_QUEUE_STALL_STATS_EN
               stall_cycles, full_cycles,
`endif
               err_sticky
    );

endinterface

// File: rtl/alu_wb_queue_wbq_storage.sv
// wbq_storage
// DEPTH x ENTRY_W register array with one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset.
// Ports: clk, we_i, waddr_i, wdata_i (write); raddr_i, rdata_o (read).
module wbq_storage #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 8,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Entry write on an accepted enqueue.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_wb_queue.sv
// alu_wb_queue
// Writeback queue placed between one ALU (simd/simf) and the register-file
// write arbiter. The head entry is presented with queue_entry_valid and is
// popped on queue_entry_serviced.
// Ports: clk; rst (async, active-low); bus (alu_wb_queue_if.slave) carries
// the enqueue side, flush, the head/serviced side, occupancy and err_sticky.
// Optional feature macro: ALU_WB_QUEUE_STALL_STATS_EN adds the saturating
// stall_cycles and full_cycles counters.
module alu_wb_queue
    import alu_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    alu_wb_queue_if.slave bus
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ENTRY_W  = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int MASK_LSB = entry_mask_lsb(DATA_WIDTH);
    localparam int VGPR_BIT = entry_vgpr_bit(DATA_WIDTH);
    localparam int WFID_LSB = entry_wfid_lsb(DATA_WIDTH);
    localparam int ADDR_LSB = entry_addr_lsb(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               enq_fire_s, deq_fire_s;
    logic [ENTRY_W-1:0] wdata_s, rdata_s;

    assign wdata_s = {bus.enq_dest_addr, bus.enq_wfid, bus.enq_is_vgpr,
                      bus.enq_exec_mask, bus.enq_data};

    // Next-state for pointers, count, handshake flags and error flag.
    // ready/valid are recomputed from the next count so both leave registers.
    always_comb begin
        enq_fire_s = bus.enq_valid & ready_q & ~bus.flush;
        deq_fire_s = bus.queue_entry_serviced & valid_q & ~bus.flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        if (bus.flush) begin
            // A flush drops everything offered in the same cycle and is not an error.
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_fire_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            err_d = err_q | (bus.enq_valid & ~ready_q)
                          | (bus.queue_entry_serviced & ~valid_q);
        end
        ready_d = (count_d != FULL_CNT);
        valid_d = (count_d != {CNT_W{1'b0}});
    end

    // Queue control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    wbq_storage #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .PTR_W   (PTR_W)
    ) u_storage (
        .clk     (clk),
        .we_i    (enq_fire_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    assign bus.enq_ready         = ready_q;
    assign bus.queue_entry_valid = valid_q;
    assign bus.occupancy         = count_q;
    assign bus.err_sticky        = err_q;
    assign bus.head_data         = rdata_s[DATA_WIDTH-1:0];
    assign bus.head_exec_mask    = rdata_s[MASK_LSB +: EXEC_MASK_WIDTH];
    assign bus.head_is_vgpr      = rdata_s[VGPR_BIT];
    assign bus.head_wfid         = rdata_s[WFID_LSB +: WFID_WIDTH];
    assign bus.head_dest_addr    = rdata_s[ADDR_LSB +: ADDR_WIDTH];

`ifdef ALU_WB_QUEUE_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] full_q, full_d;

    // Saturating stall/full counters; flush deliberately leaves them alone.
    always_comb begin
        stall_d = stall_q;
        full_d  = full_q;
        if (valid_q && !bus.queue_entry_serviced && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
        if ((count_q == FULL_CNT) && (full_q != 16'hFFFF)) begin
            full_d = full_q + 16'd1;
        end else begin
            full_d = full_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'd0;
            full_q  <= 16'd0;
        end else begin
            stall_q <= stall_d;
            full_q  <= full_d;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.full_cycles  = full_q;
`endif

endmodule

// File: tb/tb_alu_wb_queue.sv
// tb_alu_wb_queue
// Self-checking bench for alu_wb_queue (DEPTH=4, default widths). A queue of
// entries models the FIFO; each test task drives a scenario and compares inline.
module tb_alu_wb_queue;
    import alu_wb_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = DEF_DATA_WIDTH;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_entry_t mq[$];
    logic      merr;
    int        mstall;
    int        mfull;

    alu_wb_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(DEF_ADDR_WIDTH)) bus ();

    alu_wb_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(DEF_ADDR_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_entry_t mk(input logic [9:0] a);
        wb_entry_t e;
        e.dest_addr = a;
        e.wfid      = 6'($urandom);
        e.is_vgpr   = 1'($urandom);
        e.exec_mask = {32'($urandom), 32'($urandom)};
        for (int i = 0; i < DW / 32; i++) e.data[i*32 +: 32] = 32'($urandom);
        return e;
    endfunction

    // One clock: drive inputs, advance the reference model, sample after the edge.
    task automatic step(input logic ev, input wb_entry_t e, input logic sv, input logic fl);
        logic full;
        logic empty;
        bus.enq_valid            = ev;
        bus.enq_dest_addr        = e.dest_addr;
        bus.enq_wfid             = e.wfid;
        bus.enq_is_vgpr          = e.is_vgpr;
        bus.enq_exec_mask        = e.exec_mask;
        bus.enq_data             = e.data;
        bus.queue_entry_serviced = sv;
        bus.flush                = fl;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (!empty && !sv && mstall < 65535) mstall++;
        if (full && mfull < 65535) mfull++;
        if (fl) begin
            mq.delete();
        end else begin
            if (ev && full) merr = 1'b1;
            if (sv && empty) merr = 1'b1;
            if (sv && !empty) void'(mq.pop_front());
            if (ev && !full) mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic sv);
        wb_entry_t z;
        z = '0;
        step(1'b0, z, sv, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        bus.enq_valid = 1'b0;
        bus.queue_entry_serviced = 1'b0;
        bus.flush = 1'b0;
        mq.delete();
        merr = 1'b0;
        mstall = 0;
        mfull = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.enq_valid = 1'b0;
        bus.queue_entry_serviced = 1'b0;
        bus.flush = 1'b0;
        mq.delete();
        merr = 1'b0;
        mstall = 0;
        mfull = 0;
        #12;
        total++; if (bus.queue_entry_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.queue_entry_valid); end
        total++; if (bus.enq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.enq_ready); end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_sticky); end
`ifdef ALU_WB_QUEUE_STALL_STATS_EN
        total++; if (bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles); end
        total++; if (bus.full_cycles !== 16'd0) begin bad++; $display("FAIL reset_full got=%0d exp=0", bus.full_cycles); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        wb_entry_t e;
        e = mk(10'h012);
        e.wfid = 6'd5;
        e.exec_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b1, e, 1'b0, 1'b0);
        total++; if (bus.queue_entry_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.queue_entry_valid); end
        total++; if (bus.head_dest_addr !== 10'h012) begin bad++; $display("FAIL basic_addr got=%h exp=012", bus.head_dest_addr); end
        total++; if (bus.head_wfid !== 6'd5) begin bad++; $display("FAIL basic_wfid got=%0d exp=5", bus.head_wfid); end
        total++; if (bus.head_exec_mask !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL basic_mask got=%h", bus.head_exec_mask); end
        total++; if (bus.head_data !== e.data || bus.head_is_vgpr !== e.is_vgpr) begin bad++; $display("FAIL basic_data got_vgpr=%b exp_vgpr=%b", bus.head_is_vgpr, e.is_vgpr); end
        total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ got=%0d exp=1", bus.occupancy); end
        idle(1'b1);
        total++; if (bus.queue_entry_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid got=%b exp=0", bus.queue_entry_valid); end
    endtask

    task automatic test_fill_overflow();
        reset_dut();
        for (int i = 1; i <= 4; i++) step(1'b1, mk(10'(i)), 1'b0, 1'b0);
        total++; if (bus.enq_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.enq_ready); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL full_err_early got=%b exp=0", bus.err_sticky); end
        step(1'b1, mk(10'd5), 1'b0, 1'b0);
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.err_sticky); end
        total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL ovf_occ got=%0d exp=4", bus.occupancy); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (bus.head_dest_addr !== 10'(i)) begin bad++; $display("FAIL pop_order got=%0d exp=%0d", bus.head_dest_addr, i); end
            idle(1'b1);
        end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL drain_occ got=%0d exp=0", bus.occupancy); end
    endtask

    task automatic test_simul();
        reset_dut();
        step(1'b1, mk(10'h0A1), 1'b0, 1'b0);
        step(1'b1, mk(10'h0A2), 1'b0, 1'b0);
        step(1'b1, mk(10'h0A3), 1'b1, 1'b0);
        total++; if (bus.occupancy !== 3'd2) begin bad++; $display("FAIL simul_occ got=%0d exp=2", bus.occupancy); end
        total++; if (bus.head_dest_addr !== 10'h0A2) begin bad++; $display("FAIL simul_head got=%h exp=0a2", bus.head_dest_addr); end
        idle(1'b1);
        total++; if (bus.head_dest_addr !== 10'h0A3) begin bad++; $display("FAIL simul_last got=%h exp=0a3", bus.head_dest_addr); end
        idle(1'b1);
    endtask

    task automatic test_full_simul();
        reset_dut();
        for (int i = 1; i <= 4; i++) step(1'b1, mk(10'(16 + i)), 1'b0, 1'b0);
        step(1'b1, mk(10'h3FF), 1'b1, 1'b0);
        total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL fullsim_occ got=%0d exp=3", bus.occupancy); end
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL fullsim_err got=%b exp=1", bus.err_sticky); end
        total++; if (bus.enq_ready !== 1'b1) begin bad++; $display("FAIL fullsim_ready got=%b exp=1", bus.enq_ready); end
        total++; if (bus.head_dest_addr !== 10'd18) begin bad++; $display("FAIL fullsim_head got=%0d exp=18", bus.head_dest_addr); end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int i = 0; i < 3; i++) step(1'b1, mk(10'(i)), 1'b0, 1'b0);
        step(1'b1, mk(10'h055), 1'b1, 1'b1);
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.queue_entry_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.queue_entry_valid); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", bus.err_sticky); end
        total++; if (bus.enq_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.enq_ready); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        idle(1'b1);
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL udf_err got=%b exp=1", bus.err_sticky); end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL udf_occ got=%0d exp=0", bus.occupancy); end
        step(1'b1, mk(10'd7), 1'b0, 1'b0);
        step(1'b1, mk(10'd8), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        total++; if (bus.queue_entry_valid !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL arst_state got_valid=%b got_occ=%0d exp=0/0", bus.queue_entry_valid, bus.occupancy); end
        total++; if (bus.err_sticky !== 1'b0 || bus.enq_ready !== 1'b1) begin bad++; $display("FAIL arst_flags got_err=%b got_ready=%b exp=0/1", bus.err_sticky, bus.enq_ready); end
        mq.delete();
        merr = 1'b0;
        mstall = 0;
        mfull = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic ev, sv, fl;
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            ev = ($urandom_range(0, 9) < 6);
            sv = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 99) < 3);
            step(ev, mk(10'($urandom)), sv, fl);
            total++;
            if (bus.occupancy !== 3'(mq.size()) || bus.queue_entry_valid !== (mq.size() != 0)
                || bus.enq_ready !== (mq.size() != DEPTH) || bus.err_sticky !== merr) begin
                bad++;
                $display("FAIL rand_state cyc=%0d got occ=%0d v=%b r=%b e=%b exp occ=%0d e=%b",
                         n, bus.occupancy, bus.queue_entry_valid, bus.enq_ready, bus.err_sticky, mq.size(), merr);
            end
            if (mq.size() != 0) begin
                total++;
                if (bus.head_dest_addr !== mq[0].dest_addr || bus.head_wfid !== mq[0].wfid
                    || bus.head_is_vgpr !== mq[0].is_vgpr || bus.head_exec_mask !== mq[0].exec_mask
                    || bus.head_data !== mq[0].data) begin
                    bad++;
                    $display("FAIL rand_head cyc=%0d got addr=%h wfid=%0d exp addr=%h wfid=%0d",
                             n, bus.head_dest_addr, bus.head_wfid, mq[0].dest_addr, mq[0].wfid);
                end
            end
        end
    endtask

`ifdef ALU_WB_QUEUE_STALL_STATS_EN
    task automatic test_stats();
        reset_dut();
        step(1'b1, mk(10'd1), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) idle(1'b0);
        total++; if (bus.stall_cycles !== 16'd7) begin bad++; $display("FAIL stall7 got=%0d exp=7", bus.stall_cycles); end
        for (int i = 0; i < 3; i++) step(1'b1, mk(10'(i)), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) idle(1'b0);
        total++; if (bus.full_cycles !== 16'hFFFF) begin bad++; $display("FAIL full_sat got=%h exp=ffff", bus.full_cycles); end
        total++; if (bus.stall_cycles !== 16'(mstall)) begin bad++; $display("FAIL stall_sat got=%h exp=%h", bus.stall_cycles, mstall); end
        step(1'b0, mk(10'd0), 1'b0, 1'b1);
        total++; if (bus.full_cycles !== 16'(mfull) || bus.stall_cycles !== 16'(mstall)) begin bad++; $display("FAIL stats_flush got=%h/%h exp=%h/%h", bus.full_cycles, bus.stall_cycles, mfull, mstall); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        bus.enq_valid = 1'b0;
        bus.enq_dest_addr = 10'd0;
        bus.enq_wfid = 6'd0;
        bus.enq_is_vgpr = 1'b0;
        bus.enq_exec_mask = 64'd0;
        bus.enq_data = '0;
        bus.flush = 1'b0;
        bus.queue_entry_serviced = 1'b0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_simul();
        test_full_simul();
        test_flush();
        test_async_reset();
        test_random();
`ifdef ALU_WB_QUEUE_STALL_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
